bsg_subpod_link_fwd_scheduler: RTL and testbench



---
 rtl/bsg_manycore_pkg.sv | 10 +
 rtl/bsg_subpod_link_credit_counter.sv | 37 +++
 rtl/bsg_subpod_link_fwd_scheduler.sv | 102 ++++++++++
 tb/tb_bsg_subpod_link_fwd_scheduler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_pkg.sv
// Shared manycore types; holds the subpod forward-link scheduler state encoding.
package bsg_manycore_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } bsg_subpod_sched_state_e;

endpackage

// File: rtl/bsg_subpod_link_credit_counter.sv
// Outstanding-packet credit counter for one subpod forward link.
// Counts down on a send, up on a returned credit; starts full at max_out_p.
module bsg_subpod_link_credit_counter #(
    parameter int max_out_p = 8
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);
    localparam int cnt_width_lp = $clog2(max_out_p + 1);
    localparam logic [cnt_width_lp-1:0] max_lp = cnt_width_lp'(max_out_p);
    localparam logic [cnt_width_lp-1:0] one_lp = cnt_width_lp'(1);

    logic [cnt_width_lp-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt <= max_lp;
        end else if (inc_i && !dec_i && !full_o) begin
            r_cnt <= r_cnt + one_lp;
        end else if (dec_i && !inc_i && !empty_o) begin
            r_cnt <= r_cnt - one_lp;
        end
    end

    assign full_o  = (r_cnt == max_lp);
    assign empty_o = (r_cnt == '0);

    // A credit on a full counter means the far side returned more than it was sent.
    a_no_credit_overflow : assert property (
        @(posedge clk_i) disable iff (!reset_n_i) !(inc_i && !dec_i && full_o)
    );

endmodule

// File: rtl/bsg_subpod_link_fwd_scheduler.sv
// Round-robin dispatch of one forward-packet stream over several credit-limited subpod links,
// with a drain handshake used to quiesce the links before reconfiguration.
//
//   state   | meaning
//   RUN     | dispatching packets to eligible links
//   DRAIN   | dispatch blocked, waiting for every link's credits to return
//   DRAINED | all links idle with nothing outstanding; drained_o high
module bsg_subpod_link_fwd_scheduler
    import bsg_manycore_pkg::*;
#(
    parameter int num_links_p  = 2,
    parameter int data_width_p = 32,
    parameter int max_out_p    = 8
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [data_width_p-1:0]                  data_i,
    input  logic                                     v_i,
    output logic                                     ready_and_o,
    output logic [num_links_p-1:0][data_width_p-1:0] link_data_o,
    output logic [num_links_p-1:0]                   link_v_o,
    input  logic [num_links_p-1:0]                   link_ready_and_i,
    input  logic [num_links_p-1:0]                   link_credit_i,
    input  logic [num_links_p-1:0]                   link_en_i,
    input  logic                                     drain_i,
    output logic                                     drained_o
);
    localparam int rr_width_lp = (num_links_p > 1) ? $clog2(num_links_p) : 1;
    localparam logic [rr_width_lp-1:0] last_lp = rr_width_lp'(num_links_p - 1);

    bsg_subpod_sched_state_e r_state, w_state_next;
    logic [rr_width_lp-1:0]  r_rr, w_sel, w_idx;
    logic [num_links_p-1:0]  w_full, w_empty, w_elig, w_grant;
    int                      w_off;

    for (genvar k = 0; k < num_links_p; k++) begin : g_link
        bsg_subpod_link_credit_counter #(.max_out_p(max_out_p)) u_credit (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .inc_i     (link_credit_i[k]),
            .dec_i     (link_v_o[k]),
            .full_o    (w_full[k]),
            .empty_o   (w_empty[k])
        );
    end

    // Reset gating keeps ready/valid low while reset is held even though counters read full.
    always_comb begin
        w_elig = '0;
        for (int k = 0; k < num_links_p; k++) begin
            w_elig[k] = reset_n_i & link_en_i[k] & ~w_empty[k] & link_ready_and_i[k]
                        & (r_state == RUN) & ~drain_i;
        end
    end

    // Scan from the highest offset down so the nearest eligible link after r_rr wins.
    always_comb begin
        w_sel = r_rr;
        w_idx = '0;
        w_off = 0;
        for (int i = num_links_p - 1; i >= 0; i--) begin
            w_off = int'(r_rr) + i;
            if (w_off >= num_links_p) w_off = w_off - num_links_p;
            w_idx = rr_width_lp'(w_off);
            if (w_elig[w_idx]) w_sel = w_idx;
        end
        w_grant = '0;
        if (|w_elig) w_grant[w_sel] = 1'b1;
    end

    assign ready_and_o = |w_elig;
    assign link_v_o    = w_grant & {num_links_p{v_i}};
    assign link_data_o = {num_links_p{data_i}};
    assign drained_o   = (r_state == DRAINED);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rr <= '0;
        end else if (v_i && ready_and_o) begin
            r_rr <= (w_sel == last_lp) ? '0 : w_sel + rr_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= RUN;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (drain_i) w_state_next = DRAIN;
            DRAIN: begin
                if (!drain_i)    w_state_next = RUN;
                else if (&w_full) w_state_next = DRAINED;
            end
            DRAINED: if (!drain_i) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_bsg_subpod_link_fwd_scheduler.sv
// Randomized scoreboard bench for the subpod forward-link scheduler.
module tb_bsg_subpod_link_fwd_scheduler;
    localparam int N   = 3;
    localparam int W   = 16;
    localparam int MAX = 3;
    localparam int CYCLES = 4000;

    logic                  clk_i = 1'b0;
    logic                  reset_n_i;
    logic [W-1:0]          data_i;
    logic                  v_i;
    logic                  ready_and_o;
    logic [N-1:0][W-1:0]   link_data_o;
    logic [N-1:0]          link_v_o;
    logic [N-1:0]          link_ready_and_i;
    logic [N-1:0]          link_credit_i;
    logic [N-1:0]          link_en_i;
    logic                  drain_i;
    logic                  drained_o;

    always #5 clk_i = ~clk_i;

    bsg_subpod_link_fwd_scheduler #(
        .num_links_p  (N),
        .data_width_p (W),
        .max_out_p    (MAX)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .data_i           (data_i),
        .v_i              (v_i),
        .ready_and_o      (ready_and_o),
        .link_data_o      (link_data_o),
        .link_v_o         (link_v_o),
        .link_ready_and_i (link_ready_and_i),
        .link_credit_i    (link_credit_i),
        .link_en_i        (link_en_i),
        .drain_i          (drain_i),
        .drained_o        (drained_o)
    );

    typedef struct {
        logic         ready;
        logic [N-1:0] v;
        logic         drained;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: credits left per link, next link to try, and a quiesce mode
    // (0 = dispatching, 1 = waiting for credits, 2 = quiesced).
    int cnt[N];
    int rr;
    int mode;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) cnt[k] = MAX;
        rr   = 0;
        mode = 0;
    endfunction

    function automatic int pick();
        int k;
        for (int off = 0; off < N; off++) begin
            k = (rr + off) % N;
            if (link_en_i[k] && cnt[k] > 0 && link_ready_and_i[k] && mode == 0 && !drain_i)
                return k;
        end
        return -1;
    endfunction

    function automatic void model_step();
        int g;
        bit all_full;
        if (!reset_n_i) return;
        g = pick();
        all_full = 1'b1;
        for (int k = 0; k < N; k++) if (cnt[k] != MAX) all_full = 1'b0;
        if (v_i && g >= 0) begin
            cnt[g] = cnt[g] - 1;
            rr = (g + 1) % N;
        end
        for (int k = 0; k < N; k++) if (link_credit_i[k]) cnt[k] = cnt[k] + 1;
        case (mode)
            0: if (drain_i) mode = 1;
            1: if (!drain_i) mode = 0; else if (all_full) mode = 2;
            default: if (!drain_i) mode = 0;
        endcase
    endfunction

    function automatic void push_expected();
        exp_t e;
        int g;
        g = pick();
        e.ready   = reset_n_i && (g >= 0);
        e.v       = (reset_n_i && v_i && g >= 0) ? (N'(1) << g) : '0;
        e.drained = reset_n_i && (mode == 2);
        e.data    = data_i;
        exp_q.push_back(e);
    endfunction

    function automatic void drive_random(int cyc);
        logic rst_now;
        rst_now = !((cyc >= 1500 && cyc < 1503) || (cyc >= 2800 && cyc < 2802));
        if (!rst_now && reset_n_i) model_reset();
        reset_n_i = rst_now;
        v_i    = ($urandom_range(3) != 0);
        data_i = W'($urandom);
        if (cyc % 250 == 0) begin
            for (int k = 0; k < N; k++) link_en_i[k] = ($urandom_range(4) != 0);
            if (cyc < 250) link_en_i = '1;
        end
        for (int k = 0; k < N; k++) begin
            link_ready_and_i[k] = (cyc < 100) ? 1'b1 : ($urandom_range(3) != 0);
            link_credit_i[k]    = rst_now && (cnt[k] < MAX) && ($urandom_range(2) == 0);
        end
        if ($urandom_range(39) == 0) drain_i = ~drain_i;
    endfunction

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (ready_and_o !== mon_e.ready) begin
                n_errors++;
                $display("FAIL ready_and_o t=%0t got=%b exp=%b", $time, ready_and_o, mon_e.ready);
            end
            n_checks++;
            if (link_v_o !== mon_e.v) begin
                n_errors++;
                $display("FAIL link_v_o t=%0t got=%b exp=%b", $time, link_v_o, mon_e.v);
            end
            n_checks++;
            if (drained_o !== mon_e.drained) begin
                n_errors++;
                $display("FAIL drained_o t=%0t got=%b exp=%b", $time, drained_o, mon_e.drained);
            end
            n_checks++;
            if (link_data_o !== {N{mon_e.data}}) begin
                n_errors++;
                $display("FAIL link_data_o t=%0t got=%h exp=%h", $time, link_data_o, {N{mon_e.data}});
            end
        end
    end

    initial begin
        reset_n_i        = 1'b0;
        data_i           = '0;
        v_i              = 1'b0;
        link_ready_and_i = '0;
        link_credit_i    = '0;
        link_en_i        = '1;
        drain_i          = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            v_i              = 1'b1;
            link_ready_and_i = '1;
            push_expected();
        end
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk_i);
            model_step();
            #1;
            if (cyc == 0) reset_n_i = 1'b1;
            drive_random(cyc);
            push_expected();
        end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain leftover=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
